// File: rtl/dht11_sensor_emu.sv
// dht11_sensor_emu: DHT11 sensor-side responder that answers a host start pulse with a 40-bit frame
module dht11_sensor_emu #(
  parameter int unsigned TICKS_PER_US  = 100,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30,
  parameter int unsigned RESP_LOW_US   = 80,
  parameter int unsigned RESP_HIGH_US  = 80,
  parameter int unsigned BIT_LOW_US    = 50,
  parameter int unsigned BIT0_HIGH_US  = 26,
  parameter int unsigned BIT1_HIGH_US  = 70,
  parameter int unsigned COOLDOWN_US   = 1000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       DATA_IN,
  output logic       DATA_OE,
  input  logic [7:0] HUM_INT,
  input  logic [7:0] HUM_FLOAT,
  input  logic [7:0] TEMP_INT,
  input  logic [7:0] TEMP_FLOAT,
  output logic       BUSY,
  output logic       FRAME_DONE,
  output logic       START_ERR
);
  localparam logic [31:0] START_T = 32'(START_MIN_US * TICKS_PER_US);
  localparam logic [31:0] RW_T    = 32'(RESP_DELAY_US * TICKS_PER_US);
  localparam logic [31:0] RL_T    = 32'(RESP_LOW_US * TICKS_PER_US);
  localparam logic [31:0] RH_T    = 32'(RESP_HIGH_US * TICKS_PER_US);
  localparam logic [31:0] BL_T    = 32'(BIT_LOW_US * TICKS_PER_US);
  localparam logic [31:0] B0_T    = 32'(BIT0_HIGH_US * TICKS_PER_US);
  localparam logic [31:0] B1_T    = 32'(BIT1_HIGH_US * TICKS_PER_US);
  localparam logic [31:0] CD_T    = 32'(COOLDOWN_US * TICKS_PER_US);

  typedef enum logic [3:0] {
    IDLE, START_MEAS, RESP_WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW, COOLDOWN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d, dur;
  logic [39:0] sh_q, sh_d;
  logic [5:0]  bit_q, bit_d;
  logic [2:0]  sync_q, sync_d;
  logic        oe_q, oe_d;
  logic        line_s, fall, last, long_enough;
  logic [7:0]  chk;

  assign line_s      = sync_q[1];
  assign fall        = sync_q[2] & ~sync_q[1];
  assign chk         = HUM_INT + HUM_FLOAT + TEMP_INT + TEMP_FLOAT;
  assign long_enough = cnt_q + 32'd1 >= START_T;
  assign last        = cnt_q == dur - 32'd1;
  assign DATA_OE     = oe_q;
  assign BUSY        = state_q != IDLE && state_q != START_MEAS;
  assign FRAME_DONE  = EN && state_q == END_LOW && last;
  assign START_ERR   = EN && state_q == START_MEAS && line_s && !long_enough;

  // length of the phase the current state represents
  always_comb
    dur = state_q == RESP_WAIT ? RW_T :
          state_q == RESP_LOW  ? RL_T :
          state_q == RESP_HIGH ? RH_T :
          state_q == BIT_HIGH  ? (sh_q[39] ? B1_T : B0_T) :
          state_q == COOLDOWN  ? CD_T : BL_T;

  // protocol sequencing, frame latch/shift and phase counter
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    sync_d  = {sync_q[1:0], DATA_IN};
    case (state_q)
      IDLE:       if (fall) state_d = START_MEAS;
      START_MEAS: if (line_s) begin
        state_d = long_enough ? RESP_WAIT : IDLE;
        sh_d    = long_enough ? {HUM_INT, HUM_FLOAT, TEMP_INT, TEMP_FLOAT, chk} : sh_q;
        bit_d   = '0;
      end
      RESP_WAIT:  if (last) state_d = RESP_LOW;
      RESP_LOW:   if (last) state_d = RESP_HIGH;
      RESP_HIGH:  if (last) state_d = BIT_LOW;
      BIT_LOW:    if (last) state_d = BIT_HIGH;
      BIT_HIGH:   if (last) begin
        state_d = bit_q == 6'd39 ? END_LOW : BIT_LOW;
        sh_d    = bit_q == 6'd39 ? sh_q : {sh_q[38:0], 1'b0};
        bit_d   = bit_q == 6'd39 ? bit_q : bit_q + 6'd1;
      end
      END_LOW:    if (last) state_d = COOLDOWN;
      COOLDOWN:   if (last) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    if (!EN) state_d = IDLE;
    cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 32'd1;
    oe_d  = state_d == RESP_LOW || state_d == BIT_LOW || state_d == END_LOW;
  end

  // state, counter, frame and synchroniser registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      sync_q  <= 3'b111;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      sync_q  <= sync_d;
      oe_q    <= oe_d;
    end
  end
endmodule

// File: tb/tb_dht11_sensor_emu.sv
// tb_dht11_sensor_emu: scoreboard bench decoding the emulated DHT11 waveform against a frame model
module tb_dht11_sensor_emu;
  logic clk = 0, rst = 1, en = 1, host_low = 0;
  logic [7:0] hi = 0, hf = 0, ti = 0, tf = 0;
  logic data_oe, busy, frame_done, start_err, data_in;
  int checks = 0, failures = 0, err_cnt = 0, exp_err = 0;

  typedef struct {logic [39:0] f; bit ab;} exp_t;
  exp_t exp_q[$];

  assign data_in = ~(host_low | data_oe);

  dht11_sensor_emu #(.TICKS_PER_US(1), .START_MIN_US(2000), .COOLDOWN_US(1000)) dut (
    .CLK(clk), .RST(rst), .EN(en), .DATA_IN(data_in), .DATA_OE(data_oe),
    .HUM_INT(hi), .HUM_FLOAT(hf), .TEMP_INT(ti), .TEMP_FLOAT(tf),
    .BUSY(busy), .FRAME_DONE(frame_done), .START_ERR(start_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] model(input logic [7:0] a, b, c, d);
    int s = int'(a) + int'(b) + int'(c) + int'(d);
    return {a, b, c, d, 8'(s % 256)};
  endfunction

  always @(negedge clk) if (start_err) err_cnt++;

  initial begin : mon
    int runs[$];
    int cur, cyc, fd_n, fd_at, se_n, bad, tot;
    logic lvl;
    logic [39:0] got;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        runs.delete();
        cur = 0; cyc = 0; fd_n = 0; fd_at = -1; se_n = 0; lvl = 0;
        while (busy === 1'b1 && cyc < 20000) begin
          if (data_oe !== lvl) begin
            runs.push_back(cur);
            cur = 0;
            lvl = data_oe;
          end
          cur++;
          if (frame_done) begin fd_n++; fd_at = cyc; end
          if (start_err) se_n++;
          cyc++;
          @(negedge clk);
        end
        runs.push_back(cur);
        chk("busy_bounded", cyc < 20000, 1);
        if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
        else begin
          e = exp_q.pop_front();
          if (e.ab) chk("abort_truncated", runs.size() < 85 && fd_n == 0, 1);
          else begin
            chk("run_count", runs.size(), 85);
            if (runs.size() == 85) begin
              bad = 0; tot = 0; got = 0;
              for (int k = 0; k < 40; k++) begin
                got = {got[38:0], runs[4+2*k] == 70};
                bad += int'(runs[4+2*k] != 70 && runs[4+2*k] != 26) + int'(runs[3+2*k] != 50);
              end
              foreach (runs[i]) tot += runs[i];
              chk("resp_wait", runs[0], 30);
              chk("resp_low", runs[1], 80);
              chk("resp_high", runs[2], 80);
              chk("bit_timing_bad", bad, 0);
              chk("frame", got, e.f);
              chk("end_low", runs[83], 50);
              chk("cooldown", runs[84], 1000);
              chk("frame_done_cnt", fd_n, 1);
              chk("frame_done_pos", fd_at, tot - 1001);
              chk("start_err_in_frame", se_n, 0);
            end
          end
        end
      end
    end
  end

  task automatic host_start(input int lo);
    @(posedge clk) #1 host_low = 1;
    repeat (lo) @(posedge clk);
    #1 host_low = 0;
  endtask

  task automatic set_pl(input logic [7:0] a, b, c, d);
    hi = a; hf = b; ti = c; tf = d;
  endtask

  task automatic rand_pl();
    set_pl(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic start_frame(input int lo);
    exp_t e;
    e.f = model(hi, hf, ti, tf);
    e.ab = 0;
    exp_q.push_back(e);
    host_start(lo);
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n < 20000, 1);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_rise", n < 5000, 1);
  endtask

  initial begin
    exp_t e;
    int n, rises;
    logic prev;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_oe", data_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_start_err", start_err, 0);
    @(posedge clk) #1 rst = 0;
    repeat (10) @(posedge clk);

    set_pl(55, 0, 24, 3);
    start_frame(2000 + $urandom_range(0, 40));
    drain();

    for (int i = 0; i < 3; i++) begin
      host_start(i == 0 ? 1999 : $urandom_range(50, 1500));
      exp_err++;
      repeat (10) @(negedge clk);
      chk("start_err_cnt", err_cnt, exp_err);
      chk("short_busy", busy, 0);
      chk("short_oe", data_oe, 0);
      repeat (20) @(posedge clk);
    end

    set_pl(200, 200, 100, 100);
    start_frame(2000);
    drain();

    set_pl(55, 0, 24, 3);
    start_frame(2000 + $urandom_range(0, 40));
    wait_busy();
    repeat (700) @(negedge clk);
    set_pl(8'hff, 8'hff, 8'hff, 8'hff);
    drain();

    rand_pl();
    e.f = 0;
    e.ab = 1;
    exp_q.push_back(e);
    host_start(2000 + $urandom_range(0, 40));
    wait_busy();
    n = 0; rises = 0; prev = data_oe;
    while (rises < 14 && n < 5000) begin
      @(negedge clk);
      if (data_oe && !prev) rises++;
      prev = data_oe;
      n++;
    end
    chk("bit12_reached", n < 5000, 1);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    @(posedge clk) #1;
    chk("abort_oe", data_oe, 0);
    chk("abort_busy", busy, 0);
    rst = 0;
    drain();
    rand_pl();
    start_frame(2000 + $urandom_range(0, 40));
    drain();

    @(posedge clk) #1 en = 0;
    host_low = 1;
    repeat (500) @(posedge clk);
    #1 en = 1;
    repeat (1700) @(posedge clk);
    #1 host_low = 0;
    repeat (20) @(negedge clk);
    chk("en_rise_busy", busy, 0);
    chk("en_rise_err", err_cnt, exp_err);

    rand_pl();
    start_frame(2000 + $urandom_range(0, 40));
    n = 0;
    while (!frame_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done_seen", n < 20000, 1);
    repeat (100) @(negedge clk);
    host_start(2000);
    repeat (20) @(negedge clk);
    chk("cooldown_ignore_busy", busy, 0);
    chk("cooldown_ignore_err", err_cnt, exp_err);
    drain();
    rand_pl();
    start_frame(2000 + $urandom_range(0, 40));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
